// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : imem_pkg
// Purpose : Shared types and constants for the instruction-memory byte-port
//           controller: FSM state encoding, word/byte geometry and the
//           requester index (0 = fetch, 1 = loader).
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package imem_pkg;

  localparam int BytesPerWord = 4;
  localparam int ByteBits     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    LAST  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_LOAD  = 1'b1
  } req_idx_t;

endpackage
`default_nettype wire

// File: rtl/imem_port_ctrl_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter2
// Purpose : Two-request round-robin arbiter. With both requests active, the
//           requester that did not win most recently is granted. After reset
//           the fetch requester (index 0) has priority.
// Ports   : clk, rst  - clock, asynchronous active-high reset
//           en        - arbitration enable; no grant while low
//           req[1:0]  - requests, bit 0 = fetch, bit 1 = loader
//           gnt[1:0]  - one-hot grant (combinational)
// Rev     : 1.0  initial release
// ============================================================================
module rr_arbiter2
  import imem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_idx_t last;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        gnt = (last == REQ_FETCH) ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
    end
  end

  // Pointer resets to "loader won last" so fetch wins the first contest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= REQ_LOAD;
    end else if (gnt[0]) begin
      last <= REQ_FETCH;
    end else if (gnt[1]) begin
      last <= REQ_LOAD;
    end
  end

endmodule
`default_nettype wire

// File: rtl/imem_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : imem_port_ctrl
// Purpose : Sequencer/arbiter sharing a synchronous byte-wide instruction
//           memory between the fetch stage and the program loader. Each
//           32-bit access becomes four big-endian byte beats.
// Ports   : clk_i, rst_i              - clock, async active-high reset
//           if_req/addr/gnt/rvalid/rdata - fetch read port
//           ld_req/we/addr/wdata/gnt/rvalid/rdata - loader read/write port
//           mem_en/we/addr/wdata, mem_rdata_i - byte memory port
// Rev     : 1.0  initial release
// ============================================================================
module imem_port_ctrl
  import imem_pkg::*;
#(
  parameter int RegBits  = 32,
  parameter int AddrBits = 15
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                if_req_i,
  input  logic [RegBits-1:0]  if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [RegBits-1:0]  if_rdata_o,
  input  logic                ld_req_i,
  input  logic                ld_we_i,
  input  logic [RegBits-1:0]  ld_addr_i,
  input  logic [RegBits-1:0]  ld_wdata_i,
  output logic                ld_gnt_o,
  output logic                ld_rvalid_o,
  output logic [RegBits-1:0]  ld_rdata_o,
  output logic                mem_en_o,
  output logic                mem_we_o,
  output logic [AddrBits-1:0] mem_addr_o,
  output logic [ByteBits-1:0] mem_wdata_o,
  input  logic [ByteBits-1:0] mem_rdata_i
);

  state_t             state;
  logic [1:0]         beat;
  logic               we;
  req_idx_t           owner;
  logic [RegBits-1:0] wshift;    // remaining write bytes, next one at the top
  logic [RegBits-1:0] asm_word;  // read assembly, bytes shift in from the bottom
  logic [1:0]         arb_gnt;

  // Request address bits above the memory size are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr_i[RegBits-1:AddrBits], ld_addr_i[RegBits-1:AddrBits]};

  rr_arbiter2 u_arb (
    .clk (clk_i),
    .rst (rst_i),
    .en  (state == IDLE),
    .req ({ld_req_i, if_req_i}),
    .gnt (arb_gnt)
  );

  // Grants are combinational; masking with reset keeps them low while reset
  // is asserted even though the FSM already sits in IDLE.
  assign if_gnt_o = arb_gnt[0] & ~rst_i;
  assign ld_gnt_o = arb_gnt[1] & ~rst_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      beat        <= 2'd0;
      we          <= 1'b0;
      owner       <= REQ_FETCH;
      wshift      <= '0;
      asm_word    <= '0;
      if_rvalid_o <= 1'b0;
      if_rdata_o  <= '0;
      ld_rvalid_o <= 1'b0;
      ld_rdata_o  <= '0;
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      if_rvalid_o <= 1'b0;
      ld_rvalid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_gnt_o) begin
            state       <= ISSUE;
            beat        <= 2'd0;
            owner       <= REQ_LOAD;
            we          <= ld_we_i;
            mem_en_o    <= 1'b1;
            mem_we_o    <= ld_we_i;
            mem_addr_o  <= ld_addr_i[AddrBits-1:0];
            mem_wdata_o <= ld_we_i ? ld_wdata_i[RegBits-1 -: ByteBits] : '0;
            wshift      <= ld_we_i ? (ld_wdata_i << ByteBits) : '0;
          end else if (if_gnt_o) begin
            state       <= ISSUE;
            beat        <= 2'd0;
            owner       <= REQ_FETCH;
            we          <= 1'b0;
            mem_en_o    <= 1'b1;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= if_addr_i[AddrBits-1:0];
            mem_wdata_o <= '0;
            wshift      <= '0;
          end
        end
        ISSUE: begin
          // Read data lags the enable by one cycle, so beat k delivers byte k-1.
          if (beat != 2'd0 && !we) begin
            asm_word <= {asm_word[RegBits-ByteBits-1:0], mem_rdata_i};
          end
          if (beat == 2'd3) begin
            beat        <= 2'd0;
            mem_en_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            if (we) begin
              state       <= RESP;
              ld_rvalid_o <= 1'b1;
              ld_rdata_o  <= '0;
            end else begin
              state <= LAST;
            end
          end else begin
            beat        <= beat + 2'd1;
            mem_addr_o  <= mem_addr_o + 1'b1;  // wraps modulo memory size
            mem_wdata_o <= wshift[RegBits-1 -: ByteBits];
            wshift      <= wshift << ByteBits;
          end
        end
        LAST: begin
          state <= RESP;
          if (owner == REQ_LOAD) begin
            ld_rvalid_o <= 1'b1;
            ld_rdata_o  <= {asm_word[RegBits-ByteBits-1:0], mem_rdata_i};
          end else begin
            if_rvalid_o <= 1'b1;
            if_rdata_o  <= {asm_word[RegBits-ByteBits-1:0], mem_rdata_i};
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_imem_port_ctrl
// Purpose : Directed self-checking bench for imem_port_ctrl with a byte-wide
//           synchronous memory model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_imem_port_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        ld_req = 1'b0, ld_we = 1'b0;
  logic [31:0] ld_addr = '0, ld_wdata = '0;
  logic        ld_gnt, ld_rvalid;
  logic [31:0] ld_rdata;
  logic        mem_en, mem_we;
  logic [14:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imem_port_ctrl #(.RegBits(32), .AddrBits(15)) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .ld_req_i(ld_req), .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_wdata_i(ld_wdata),
    .ld_gnt_o(ld_gnt), .ld_rvalid_o(ld_rvalid), .ld_rdata_o(ld_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  // Memory model; preload port used only while the DUT is idle.
  logic [7:0]  mem [0:32767];
  logic        pl_we = 1'b0;
  logic [14:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;

  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    else if (pl_we) mem[pl_addr] <= pl_data;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
  end

  task automatic preload(input logic [14:0] a, input logic [7:0] d);
    @(negedge clk); pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk); pl_we = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk); if_req = 1'b1; ld_req = 1'b1; #1;
    total++;
    if ({if_gnt, ld_gnt, if_rvalid, ld_rvalid, mem_en, mem_we, mem_addr, mem_wdata, if_rdata, ld_rdata} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: gnt=%b%b rv=%b%b en=%b we=%b addr=%h wd=%h ifr=%h ldr=%h, want all 0",
               if_gnt, ld_gnt, if_rvalid, ld_rvalid, mem_en, mem_we, mem_addr, mem_wdata, if_rdata, ld_rdata);
    end
    if_req = 1'b0; ld_req = 1'b0;
  endtask

  task automatic test_fetch_read;
    logic [14:0] ea;
    @(negedge clk); if_req = 1'b1; if_addr = 32'h0000_0010; #1;
    total++;
    if (if_gnt !== 1'b1 || ld_gnt !== 1'b0) begin
      bad++; $display("FAIL fetch_gnt: if_gnt=%b ld_gnt=%b want 1 0", if_gnt, ld_gnt);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); if_req = 1'b0;
      ea = 15'h0010 + 15'(k);
      total++;
      if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== ea) begin
        bad++; $display("FAIL fetch_beat%0d: en=%b we=%b addr=%h want 1 0 %h", k, mem_en, mem_we, mem_addr, ea);
      end
    end
    @(negedge clk);
    total++;
    if (mem_en !== 1'b0 || if_rvalid !== 1'b0 || mem_addr !== 15'h0) begin
      bad++; $display("FAIL fetch_last: en=%b rvalid=%b addr=%h want 0 0 0", mem_en, if_rvalid, mem_addr);
    end
    @(negedge clk);
    total++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'h1300_0593) begin
      bad++; $display("FAIL fetch_resp: rvalid=%b rdata=%h want 1 13000593", if_rvalid, if_rdata);
    end
    @(negedge clk);
    total++;
    if (if_rvalid !== 1'b0 || if_rdata !== 32'h1300_0593) begin
      bad++; $display("FAIL fetch_pulse: rvalid=%b rdata=%h want 0 13000593", if_rvalid, if_rdata);
    end
  endtask

  task automatic test_write_then_read;
    logic [7:0] wb [4];
    logic [14:0] ea;
    wb = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    @(negedge clk); ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h0000_0020; ld_wdata = 32'hDEAD_BEEF; #1;
    total++;
    if (ld_gnt !== 1'b1 || if_gnt !== 1'b0) begin
      bad++; $display("FAIL write_gnt: ld_gnt=%b if_gnt=%b want 1 0", ld_gnt, if_gnt);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); ld_req = 1'b0;
      ea = 15'h0020 + 15'(k);
      total++;
      if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== ea || mem_wdata !== wb[k]) begin
        bad++; $display("FAIL write_beat%0d: en=%b we=%b addr=%h wd=%h want 1 1 %h %h",
                        k, mem_en, mem_we, mem_addr, mem_wdata, ea, wb[k]);
      end
    end
    @(negedge clk);
    total++;
    if (ld_rvalid !== 1'b1 || ld_rdata !== 32'h0 || mem_en !== 1'b0 || mem_we !== 1'b0) begin
      bad++; $display("FAIL write_resp: rvalid=%b rdata=%h en=%b we=%b want 1 0 0 0", ld_rvalid, ld_rdata, mem_en, mem_we);
    end
    total++;
    if (if_rdata !== 32'h1300_0593 || if_rvalid !== 1'b0) begin
      bad++; $display("FAIL fetch_rdata_stable: rdata=%h rvalid=%b want 13000593 0", if_rdata, if_rvalid);
    end
    @(negedge clk); ld_we = 1'b0;
    if_req = 1'b1; if_addr = 32'h0000_0020; #1;
    total++;
    if (if_gnt !== 1'b1 || ld_rvalid !== 1'b0) begin
      bad++; $display("FAIL readback_gnt: if_gnt=%b ld_rvalid=%b want 1 0", if_gnt, ld_rvalid);
    end
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk); if_req = 1'b0;
    end
    total++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEAD_BEEF || ld_rdata !== 32'h0) begin
      bad++; $display("FAIL readback: rvalid=%b rdata=%h ld_rdata=%h want 1 deadbeef 0", if_rvalid, if_rdata, ld_rdata);
    end
  endtask

  task automatic test_wrap;
    logic [14:0] ea [4];
    ea = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001};
    @(negedge clk); if_req = 1'b1; if_addr = 32'h8000_7FFE;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); if_req = 1'b0;
      total++;
      if (mem_en !== 1'b1 || mem_addr !== ea[k]) begin
        bad++; $display("FAIL wrap_beat%0d: en=%b addr=%h want 1 %h", k, mem_en, mem_addr, ea[k]);
      end
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'h1122_3344) begin
      bad++; $display("FAIL wrap_data: rvalid=%b rdata=%h want 1 11223344", if_rvalid, if_rdata);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    int who [4];
    int at  [4];
    int exp_who [4];
    int exp_at  [4];
    exp_who = '{0, 1, 0, 1};
    exp_at  = '{0, 7, 13, 20};
    who = '{-1, -1, -1, -1};
    at  = '{-1, -1, -1, -1};
    n = 0;
    @(negedge clk); rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h0000_0010;
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h0000_0040; ld_wdata = 32'h0102_0304;
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (if_gnt || ld_gnt) begin
        who[n] = ld_gnt ? 1 : 0;
        at[n]  = c;
        n++;
      end
    end
    total++;
    if (n != 4) begin
      bad++; $display("FAIL b2b_grant_count: got %0d grants want 4", n);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (who[i] != exp_who[i] || at[i] != exp_at[i]) begin
        bad++; $display("FAIL b2b_grant%0d: who=%0d cycle=%0d want who=%0d cycle=%0d", i, who[i], at[i], exp_who[i], exp_at[i]);
      end
    end
    @(negedge clk); if_req = 1'b0; ld_req = 1'b0; ld_we = 1'b0;
    repeat (7) @(negedge clk);
  endtask

  task automatic test_reset_mid_read;
    int pulses;
    pulses = 0;
    @(negedge clk); if_req = 1'b1; if_addr = 32'h0000_0010;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h0000_0020;
    #1;
    total++;
    if (if_gnt !== 1'b1) begin
      bad++; $display("FAIL abort_gnt: if_gnt=%b want 1", if_gnt);
    end
    repeat (3) @(negedge clk);   // beat 0, 1, 2
    total++;
    if (mem_en !== 1'b1 || mem_addr !== 15'h0012) begin
      bad++; $display("FAIL abort_beat2: en=%b addr=%h want 1 0012", mem_en, mem_addr);
    end
    rst = 1'b1; #1;
    total++;
    if ({if_gnt, ld_gnt, if_rvalid, ld_rvalid, mem_en, mem_we, mem_addr, mem_wdata, if_rdata, ld_rdata} !== '0) begin
      bad++;
      $display("FAIL abort_outputs: gnt=%b%b rv=%b%b en=%b we=%b addr=%h wd=%h ifr=%h ldr=%h, want all 0",
               if_gnt, ld_gnt, if_rvalid, ld_rvalid, mem_en, mem_we, mem_addr, mem_wdata, if_rdata, ld_rdata);
    end
    repeat (2) begin
      @(negedge clk); if (if_rvalid) pulses++;
    end
    rst = 1'b0; #1;
    total++;
    if (if_gnt !== 1'b1 || ld_gnt !== 1'b0) begin
      bad++; $display("FAIL abort_prio: if_gnt=%b ld_gnt=%b want 1 0", if_gnt, ld_gnt);
    end
    if_req = 1'b0; #1;
    total++;
    if (ld_gnt !== 1'b1 || if_gnt !== 1'b0) begin
      bad++; $display("FAIL abort_ld_alone: ld_gnt=%b if_gnt=%b want 1 0", ld_gnt, if_gnt);
    end
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk); ld_req = 1'b0;
      if (if_rvalid) pulses++;
    end
    total++;
    if (ld_rvalid !== 1'b1 || ld_rdata !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL abort_ld_read: rvalid=%b rdata=%h want 1 deadbeef", ld_rvalid, ld_rdata);
    end
    repeat (2) begin
      @(negedge clk); if (if_rvalid) pulses++;
    end
    total++;
    if (pulses != 0) begin
      bad++; $display("FAIL abort_no_rvalid: if_rvalid pulses=%0d want 0", pulses);
    end
  endtask

  initial begin
    rst = 1'b1;
    preload(15'h0010, 8'h13);
    preload(15'h0011, 8'h00);
    preload(15'h0012, 8'h05);
    preload(15'h0013, 8'h93);
    preload(15'h7FFE, 8'h11);
    preload(15'h7FFF, 8'h22);
    preload(15'h0000, 8'h33);
    preload(15'h0001, 8'h44);
    test_reset;
    @(negedge clk); rst = 1'b0;
    test_fetch_read;
    test_write_then_read;
    test_wrap;
    test_back_to_back;
    test_reset_mid_read;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_port_ctrl.md
# imem_port_ctrl

Sequencer and arbiter for the byte-wide, single-ported instruction memory. Shares one synchronous byte port between the instruction-fetch requester and the program-loader/debug requester. Serialises each 32-bit access into four byte beats in big-endian order: the byte at the base address occupies bits [31:24]. Sits between the fetch stage / loader and the memory array.

## Interface
- RegBits, 32: width of request addresses and data words; must equal 4 × 8.
- AddrBits, 15: memory address width; the memory holds 2^AddrBits bytes.

- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- if_req_i  in  1  fetch read request; held until granted.
- if_addr_i  in  RegBits  fetch byte address; stable while if_req_i is high.
- if_gnt_o  out  1  fetch request accepted this cycle.
- if_rvalid_o  out  1  one-cycle pulse: if_rdata_o valid.
- if_rdata_o  out  RegBits  fetched word.
- ld_req_i  in  1  loader request; held until granted.
- ld_we_i  in  1  1 = write, 0 = read.
- ld_addr_i  in  RegBits  loader byte address.
- ld_wdata_i  in  RegBits  loader write word.
- ld_gnt_o  out  1  loader request accepted this cycle.
- ld_rvalid_o  out  1  one-cycle pulse: read data valid, or write complete.
- ld_rdata_o  out  RegBits  loader read word; 0 after a write.
- mem_en_o  out  1  byte access enable.
- mem_we_o  out  1  byte write enable.
- mem_addr_o  out  AddrBits  byte address.
- mem_wdata_o  out  8  write byte.
- mem_rdata_i  in  8  read byte; valid the cycle after mem_en_o with mem_we_o = 0.

## Operation
- FSM states:
  - IDLE: only state that grants.
  - ISSUE: 4 cycles; beat counter k = 0..3.
  - LAST: reads only; captures byte 3.
  - RESP: 1 cycle; rvalid pulse.
- Arbitration:
  - Two-way round-robin; applied only in IDLE.
  - Single requester: that requester wins.
  - Both requesting: the one not granted most recently wins.
  - After reset, fetch has priority.
- Grant: gnt_o is combinational in IDLE, one-hot, for the winner. At that edge the controller latches address (low AddrBits bits), direction and write data.
- ISSUE beat k:
  - mem_en_o = 1; mem_addr_o = base + k, modulo 2^AddrBits (wraps; upper request bits ignored).
  - Writes drive mem_we_o = 1 and mem_wdata_o = wdata[31-8k : 24-8k].
  - Reads shift mem_rdata_i into the assembly register on beats 1..3; byte 3 is captured in LAST.
- Fetch requests are always reads; no alignment requirement.
- RESP:
  - Pulse the granted requester's rvalid_o.
  - rdata_o holds the assembled word (read) or 0 (write), and stays stable until the next response to that requester.
  - Next state IDLE.
- Outputs outside their active states: mem_en_o, mem_we_o, gnt_o and rvalid_o are 0; mem_addr_o and mem_wdata_o are 0.
- Reset (any state, mid-access included): immediately return to IDLE, clear the beat counter, assembly register, both rdata_o and all outputs to 0, and set the priority pointer to fetch. No rvalid is ever issued for an aborted access.

## Timing
- Grant at cycle T.
- Read: beats in T+1..T+4, LAST in T+5, rvalid in T+6. Latency is 6 cycles; the next grant is possible at T+7.
- Write: beats in T+1..T+4, RESP in T+5. The next grant is possible at T+6.
- A request dropped before its grant is ignored.
- Requests arriving outside IDLE wait; the requester must hold them.
- A request arriving in the RESP cycle is considered in the next IDLE cycle.

## Structure
- Package imem_pkg holds:
  - the state enum {IDLE, ISSUE, LAST, RESP};
  - BytesPerWord = 4 and ByteBits = 8;
  - the requester-index type (0 = fetch, 1 = loader).
- Sub-module rr_arbiter2: 2-request round-robin with last-grant pointer, enable input (high in IDLE), and one-hot grant output.

## Test plan
- Fetch read at 0x0000_0010 with memory bytes 0x10..0x13 = 13 00 05 93:
  - if_rvalid_o pulses at T+6 with 0x13000593;
  - mem_addr_o steps 0x10..0x13 over T+1..T+4.
- Loader write 0xDEADBEEF to 0x20, then fetch read of 0x20:
  - mem_wdata_o sequence is DE, AD, BE, EF;
  - ld_rvalid_o pulses at T+5;
  - the fetch then returns 0xDEADBEEF.
- Both requests held high continuously from reset:
  - grants alternate fetch, loader, fetch, loader;
  - fetch is granted first;
  - grants are spaced 7 cycles (read) or 6 cycles (write) apart.
- Wrap: fetch at 0x7FFE with AddrBits = 15:
  - mem_addr_o sequence is 0x7FFE, 0x7FFF, 0x0000, 0x0001;
  - the word assembles in that byte order.
- Reset asserted asynchronously during the beat-2 cycle of a read:
  - all outputs are 0 before the next edge;
  - no if_rvalid_o is issued;
  - after release, a held ld_req_i is granted before if_req_i only if fetch is not requesting (pointer reset to fetch).
